// File: rtl/prll_bus_arbiter.sv
// prll_bus_arbiter: round-robin owner arbiter for a shared tri-state parallel bus with an idle-pattern keeper.
// Optional grant-hold timeout is compiled in when PRLL_BUS_ARB_TIMEOUT_EN is defined.
module prll_bus_arbiter #(
  parameter int DRVRS = 4,
  parameter int BITS = 32,
  parameter int MAX_HOLD = 16,
  parameter logic [BITS-1:0] IDLE_PATTERN = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         req,
  output logic [DRVRS-1:0]         gnt,
  inout  wire  [BITS-1:0]          bus,
  output logic [$clog2(DRVRS)-1:0] owner,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int OW = $clog2(DRVRS);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t state, state_d;
  logic [OW-1:0] ptr, ptr_d, owner_d, owner_inc, winner, cand;
  logic [DRVRS-1:0] gnt_d;
  logic found, release_ev, timeout_ev, end_ev, busy_d;
  // The keeper drives exactly when nobody is granted, so the bus is never floating.
  assign bus = (gnt == '0) ? IDLE_PATTERN : {BITS{1'bz}};
  always_comb begin
    winner = ptr;
    found = 1'b0;
    cand = '0;
    for (int i = 0; i < DRVRS; i++) begin
      cand = OW'((int'(ptr) + i) % DRVRS);
      if (!found && req[cand]) begin
        found = 1'b1;
        winner = cand;
      end
    end
  end
  assign owner_inc = (owner == OW'(DRVRS - 1)) ? '0 : owner + 1'b1;
  assign release_ev = (state == GRANT) && !req[owner];
`ifdef PRLL_BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  // Holds the 1-based index of the current GRANT cycle; primed to 1 outside GRANT.
  always_ff @(posedge clk or posedge reset)
    if (reset) hold_cnt <= HW'(1);
    else hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : HW'(1);
  assign timeout_ev = (state == GRANT) && req[owner] && (hold_cnt == HW'(MAX_HOLD));
`else
  assign timeout_ev = 1'b0;
`endif
  assign end_ev = release_ev || timeout_ev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      gnt <= '0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      owner <= owner_d;
      gnt <= gnt_d;
      busy <= busy_d;
      timeout_err <= timeout_ev;
    end
  always_comb
    state_d = (state == IDLE)  ? (found ? GRANT : IDLE) :
              (state == GRANT) ? (end_ev ? TURN : GRANT) : IDLE;
  always_comb begin
    owner_d = (state == IDLE && found) ? winner : owner;
    ptr_d = end_ev ? owner_inc : ptr;
    busy_d = (state_d == GRANT);
    gnt_d = busy_d ? (DRVRS'(1) << owner_d) : '0;
  end
endmodule
